// File: rtl/platform_utils_ccip_mmio_csr_pkg.sv
// Shared types for the AFU-side CCI-P MMIO CSR responder: trimmed CCI-P channel
// structs, CSR index map and the request pipeline stage record.
package platform_utils_ccip_mmio_csr_pkg;

  localparam int CSR_IDX_DFH    = 0;
  localparam int CSR_IDX_ID_L   = 1;
  localparam int CSR_IDX_ID_H   = 2;
  localparam int CSR_IDX_CYCLES = 3;
  localparam int CSR_IDX_ERRCNT = 4;
  localparam int CSR_IDX_RW0    = 5;

  typedef enum logic [1:0] {
    LEN_4B  = 2'd0,
    LEN_8B  = 2'd1,
    LEN_64B = 2'd2
  } t_mmio_len;

  // Only the c0 MMIO request fields this responder consumes are carried.
  typedef struct packed {
    logic [15:0] address;
    logic [1:0]  length;
    logic [8:0]  tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef struct packed {
    t_ccip_c0_ReqMmioHdr hdr;
    logic [63:0]         data;
    logic                mmioRdValid;
    logic                mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_if_ccip_c0_Rx c0;
  } t_if_ccip_Rx;

  typedef struct packed {
    logic [8:0] tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    logic [63:0]         data;
  } t_if_ccip_c2_Tx;

  typedef struct packed {
    logic        valid;
    logic        is_rd;
    logic        is_wr;
    logic [14:0] idx;
    logic        dw;
    t_mmio_len   len;
    logic [8:0]  tid;
    logic [63:0] data;
    logic        err;
    logic        is_ro;
  } t_mmio_req_s1;

endpackage

// File: rtl/platform_utils_ccip_mmio_csr_if.sv
// CCI-P MMIO channel bundle between the shim (master) and the AFU CSR block (slave).
interface platform_utils_ccip_mmio_csr_if;
  import platform_utils_ccip_mmio_csr_pkg::*;

  t_if_ccip_Rx    cp2af_sRx;
  t_if_ccip_c2_Tx af2cp_sTxC2;

  modport master (output cp2af_sRx, input  af2cp_sTxC2);
  modport slave  (input  cp2af_sRx, output af2cp_sTxC2);

endinterface

// File: rtl/platform_utils_ccip_mmio_decode.sv
// Combinational MMIO address/length decode into a 64-bit CSR index with
// error and read-only classification.
module platform_utils_ccip_mmio_decode
  import platform_utils_ccip_mmio_csr_pkg::*;
#(
  parameter logic [15:0] CSR_BASE_ADDR = 16'h0000,
  parameter int          NUM_RW        = 4,
  parameter int          NUM_STATUS    = 2
) (
  input  logic [15:0] addr,
  input  t_mmio_len   len,
  output logic [14:0] idx,
  output logic        dw,
  output logic        err,
  output logic        is_ro
);

  localparam int N_CSR = CSR_IDX_RW0 + NUM_RW + NUM_STATUS;

  logic [15:0] off;
  logic        below;
  logic        len_bad;
  logic        out_range;

  always_comb begin
    off       = addr - CSR_BASE_ADDR;
    idx       = off[15:1];
    dw        = off[0];
    below     = (addr < CSR_BASE_ADDR);
    out_range = (int'(idx) >= N_CSR);
    case (len)
      LEN_4B:  len_bad = 1'b0;
      LEN_8B:  len_bad = off[0];
      default: len_bad = 1'b1;
    endcase
    err   = below | out_range | len_bad;
    // ERRCNT accepts an 8B clear, so only it and the scratch block are writable.
    is_ro = !((int'(idx) == CSR_IDX_ERRCNT) ||
              ((int'(idx) >= CSR_IDX_RW0) && (int'(idx) < CSR_IDX_RW0 + NUM_RW)));
  end

endmodule

// File: rtl/platform_utils_ccip_mmio_csr.sv
// AFU-side CCI-P MMIO responder: two-stage request pipeline over a 64-bit CSR bank
// (DFH, AFU ID, cycle counter, error counter, RW scratch, AFU status).
module platform_utils_ccip_mmio_csr
  import platform_utils_ccip_mmio_csr_pkg::*;
#(
  parameter logic [15:0] CSR_BASE_ADDR = 16'h0000,
  parameter logic [63:0] DFH_VALUE     = 64'h1000_0000_0000_0000,
  parameter logic [63:0] AFU_ID_L      = 64'h0,
  parameter logic [63:0] AFU_ID_H      = 64'h0,
  parameter int          NUM_RW        = 4,
  parameter int          NUM_STATUS    = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  platform_utils_ccip_mmio_csr_if.slave ccip,
  output logic [NUM_RW-1:0][63:0]      csr_rw,
  output logic [NUM_RW-1:0]            csr_wr_pulse,
  input  logic [NUM_STATUS-1:0][63:0]  csr_status
);

  t_if_ccip_c0_Rx  c0;
  t_mmio_len       req_len;
  logic            req_valid;
  logic [14:0]     dec_idx;
  logic            dec_dw;
  logic            dec_err;
  logic            dec_ro;
  t_mmio_req_s1    s1;
  t_mmio_req_s1    s1_d;
  logic [63:0]     cycles;
  logic [31:0]     errcnt;
  logic            s1_wr_ok;
  logic            errcnt_clr;
  logic            new_err;
  logic [NUM_RW-1:0] wr_mask;
  logic [NUM_RW-1:0] wr_mask_q;
  logic [63:0]     rd_val;
  logic [63:0]     rd_data;
  t_if_ccip_c2_Tx  c2_d;

  assign c0        = ccip.cp2af_sRx.c0;
  assign req_len   = t_mmio_len'(c0.hdr.length);
  assign req_valid = c0.mmioRdValid | c0.mmioWrValid;

  platform_utils_ccip_mmio_decode #(
    .CSR_BASE_ADDR (CSR_BASE_ADDR),
    .NUM_RW        (NUM_RW),
    .NUM_STATUS    (NUM_STATUS)
  ) u_decode (
    .addr  (c0.hdr.address),
    .len   (req_len),
    .idx   (dec_idx),
    .dw    (dec_dw),
    .err   (dec_err),
    .is_ro (dec_ro)
  );

  always_comb begin
    s1_d       = '0;
    s1_d.valid = req_valid;
    s1_d.is_rd = c0.mmioRdValid;
    s1_d.is_wr = c0.mmioWrValid;
    s1_d.idx   = dec_idx;
    s1_d.dw    = dec_dw;
    s1_d.len   = req_len;
    s1_d.tid   = c0.hdr.tid;
    s1_d.data  = c0.data;
    s1_d.err   = dec_err;
    s1_d.is_ro = dec_ro;
  end

  always_ff @(posedge clk) begin
    if (reset) s1 <= '0;
    else       s1 <= s1_d;
  end

  assign s1_wr_ok   = s1.valid & s1.is_wr & ~s1.err & ~s1.is_ro;
  assign errcnt_clr = s1_wr_ok & (int'(s1.idx) == CSR_IDX_ERRCNT) & (s1.len == LEN_8B);
  // Errors are counted as they enter S1, so a clear in S2 can coincide with a new error.
  assign new_err    = req_valid & dec_err;

  always_comb begin
    wr_mask = '0;
    for (int k = 0; k < NUM_RW; k++)
      wr_mask[k] = s1_wr_ok && (int'(s1.idx) == CSR_IDX_RW0 + k);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      csr_rw       <= '0;
      wr_mask_q    <= '0;
      csr_wr_pulse <= '0;
    end else begin
      wr_mask_q    <= wr_mask;
      csr_wr_pulse <= wr_mask_q;
      for (int k = 0; k < NUM_RW; k++) begin
        if (wr_mask[k]) begin
          if (s1.len == LEN_8B) csr_rw[k]        <= s1.data;
          else if (s1.dw)       csr_rw[k][63:32] <= s1.data[31:0];
          else                  csr_rw[k][31:0]  <= s1.data[31:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycles <= '0;
      errcnt <= '0;
    end else begin
      cycles <= cycles + 64'd1;
      if (errcnt_clr)
        errcnt <= {31'd0, new_err};
      else if (new_err && (errcnt != 32'hFFFF_FFFF))
        errcnt <= errcnt + 32'd1;
    end
  end

  always_comb begin
    rd_val = '0;
    case (int'(s1.idx))
      CSR_IDX_DFH:    rd_val = DFH_VALUE;
      CSR_IDX_ID_L:   rd_val = AFU_ID_L;
      CSR_IDX_ID_H:   rd_val = AFU_ID_H;
      CSR_IDX_CYCLES: rd_val = cycles;
      CSR_IDX_ERRCNT: rd_val = {32'd0, errcnt};
      default:        rd_val = '0;
    endcase
    for (int k = 0; k < NUM_RW; k++)
      if (int'(s1.idx) == CSR_IDX_RW0 + k) rd_val = csr_rw[k];
    for (int k = 0; k < NUM_STATUS; k++)
      if (int'(s1.idx) == CSR_IDX_RW0 + NUM_RW + k) rd_val = csr_status[k];

    if (s1.err)                rd_data = '0;
    else if (s1.len == LEN_4B) rd_data = {32'd0, (s1.dw ? rd_val[63:32] : rd_val[31:0])};
    else                       rd_data = rd_val;
  end

  always_comb begin
    c2_d = '0;
    if (s1.valid && s1.is_rd) begin
      c2_d.mmioRdValid = 1'b1;
      c2_d.hdr.tid     = s1.tid;
      c2_d.data        = rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ccip.af2cp_sTxC2 <= '0;
    else       ccip.af2cp_sTxC2 <= c2_d;
  end

endmodule

// File: tb/tb_platform_utils_ccip_mmio_csr.sv
// Scoreboard bench for the CCI-P MMIO CSR responder: stimulus pushes expected read
// beats, a negedge monitor pops and compares them with tid, data and latency.
module tb_platform_utils_ccip_mmio_csr;
  import platform_utils_ccip_mmio_csr_pkg::*;

  localparam logic [15:0] BASE = 16'h0020;
  localparam logic [63:0] DFH  = 64'h1000_0000_0000_0000;
  localparam logic [63:0] IDL  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] IDH  = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] ST0  = 64'h5555_0000_0000_0001;
  localparam logic [63:0] ST1  = 64'h0000_CAFE_F00D_0002;

  typedef struct {
    logic [8:0]  tid;
    logic [63:0] data;
    int          due;
    bit          cmp;
    string       name;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [3:0][63:0]  csr_rw;
  logic [3:0]        csr_wr_pulse;
  logic [1:0][63:0]  csr_status;

  int          cyc = 0;
  int          n_tot = 0;
  int          n_pass = 0;
  int          pulse0 = 0;
  exp_t        exp_q[$];
  logic [63:0] cap_q[$];

  platform_utils_ccip_mmio_csr_if bus();

  platform_utils_ccip_mmio_csr #(
    .CSR_BASE_ADDR (BASE),
    .DFH_VALUE     (DFH),
    .AFU_ID_L      (IDL),
    .AFU_ID_H      (IDH),
    .NUM_RW        (4),
    .NUM_STATUS    (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ccip         (bus.slave),
    .csr_rw       (csr_rw),
    .csr_wr_pulse (csr_wr_pulse),
    .csr_status   (csr_status)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (csr_wr_pulse[0] === 1'b1) pulse0++;
    if (bus.af2cp_sTxC2.mmioRdValid !== 1'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 64'(bus.af2cp_sTxC2.mmioRdValid), 64'h0);
      end else begin
        e = exp_q.pop_front();
        chk({e.name, "_tid"}, 64'(bus.af2cp_sTxC2.hdr.tid), 64'(e.tid));
        chk({e.name, "_latency"}, 64'(cyc), 64'(e.due));
        if (e.cmp) chk({e.name, "_data"}, bus.af2cp_sTxC2.data, e.data);
        else       cap_q.push_back(bus.af2cp_sTxC2.data);
      end
    end
  end

  function automatic logic [15:0] a8(input int i);
    return BASE + 16'(2 * i);
  endfunction

  task automatic drive(input logic rdv, input logic wrv, input logic [15:0] a,
                       input t_mmio_len len, input logic [8:0] tid, input logic [63:0] d);
    bus.cp2af_sRx.c0.mmioRdValid = rdv;
    bus.cp2af_sRx.c0.mmioWrValid = wrv;
    bus.cp2af_sRx.c0.hdr.address = a;
    bus.cp2af_sRx.c0.hdr.length  = len;
    bus.cp2af_sRx.c0.hdr.tid     = tid;
    bus.cp2af_sRx.c0.data        = d;
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [15:0] a, input t_mmio_len len, input logic [8:0] tid,
                    input logic [63:0] e, input string name, input bit cmp = 1'b1);
    exp_t x;
    x.tid = tid; x.data = e; x.due = cyc + 2; x.cmp = cmp; x.name = name;
    exp_q.push_back(x);
    drive(1'b1, 1'b0, a, len, tid, 64'h0);
  endtask

  task automatic wr(input logic [15:0] a, input t_mmio_len len, input logic [63:0] d);
    drive(1'b0, 1'b1, a, len, 9'h0, d);
  endtask

  task automatic idle(input int n);
    bus.cp2af_sRx = '0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.cp2af_sRx = '0;
    csr_status    = {ST1, ST0};
    reset         = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_c2_valid", 64'(bus.af2cp_sTxC2.mmioRdValid), 64'h0);
    chk("rst_c2_data", bus.af2cp_sTxC2.data, 64'h0);
    chk("rst_csr_rw0", csr_rw[0], 64'h0);
    chk("rst_pulse", 64'(csr_wr_pulse), 64'h0);
    reset = 1'b0;

    // Test 1: DFH read latency and tid
    rd(a8(0), LEN_8B, 9'h05, DFH, "t1_dfh");
    idle(1);
    drain();

    // Test 2: 8B then 4B write of the same scratch CSR
    wr(a8(5), LEN_8B, 64'hDEAD_BEEF_0123_4567);
    wr(a8(5) + 16'd1, LEN_4B, 64'h0000_0000_AAAA_5555);
    idle(6);
    chk("t2_csr_rw0", csr_rw[0], 64'hAAAA_5555_0123_4567);
    chk("t2_csr_rw1", csr_rw[1], 64'h0);
    chk("t2_pulse_count", 64'(pulse0), 64'd2);
    rd(a8(5) + 16'd1, LEN_4B, 9'h10, 64'h0000_0000_AAAA_5555, "t2_rd_dw1");
    rd(a8(5), LEN_4B, 9'h11, 64'h0000_0000_0123_4567, "t2_rd_dw0");
    idle(1);
    drain();

    // Test 3: write followed immediately by read of the same CSR
    wr(a8(6), LEN_8B, 64'h11);
    rd(a8(6), LEN_8B, 9'h12, 64'h11, "t3_raw");
    idle(1);
    drain();

    // Test 4: back-to-back reads, plus status CSRs
    rd(a8(0), LEN_8B, 9'h001, DFH, "t4_idx0");
    rd(a8(1), LEN_8B, 9'h002, IDL, "t4_idx1");
    rd(a8(2), LEN_8B, 9'h003, IDH, "t4_idx2");
    rd(a8(9), LEN_8B, 9'h013, ST0, "t4_status0");
    rd(a8(10) + 16'd1, LEN_4B, 9'h014, 64'h0000_0000_0000_CAFE, "t4_status1_dw1");
    idle(1);
    drain();

    // Test 5: error handling and ERRCNT
    rd(a8(11), LEN_8B, 9'h020, 64'h0, "t5_oob");
    wr(a8(5), LEN_64B, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(BASE + 16'd1, LEN_8B, 9'h021, 64'h0, "t5_misalign");
    wr(a8(0), LEN_8B, 64'h1234);
    idle(1);
    rd(a8(4), LEN_8B, 9'h022, 64'd3, "t5_errcnt3");
    rd(a8(0), LEN_8B, 9'h023, DFH, "t5_ro_kept");
    idle(1);
    drain();
    chk("t5_rw0_after_64b", csr_rw[0], 64'hAAAA_5555_0123_4567);
    chk("t5_pulse_count", 64'(pulse0), 64'd2);
    wr(a8(4), LEN_4B, 64'h0);
    idle(1);
    rd(a8(4), LEN_8B, 9'h024, 64'd3, "t5_errcnt_4b_ignored");
    wr(a8(4), LEN_8B, 64'hFFFF_FFFF);
    rd(a8(4), LEN_8B, 9'h025, 64'd0, "t5_errcnt_clear");
    rd(a8(11), LEN_8B, 9'h026, 64'h0, "t5_err_a");
    wr(a8(4), LEN_8B, 64'h0);
    rd(BASE - 16'd2, LEN_8B, 9'h027, 64'h0, "t5_below_base");
    rd(a8(4), LEN_8B, 9'h028, 64'd1, "t5_clear_with_err");
    idle(1);
    drain();

    // Test 6: cycle counter delta, then reset with a read in flight
    rd(a8(3), LEN_8B, 9'h030, 64'h0, "t6_cyc0", 1'b0);
    idle(9);
    rd(a8(3), LEN_8B, 9'h031, 64'h0, "t6_cyc1", 1'b0);
    idle(1);
    drain();
    chk("t6_cycles_captured", 64'(cap_q.size()), 64'd2);
    if (cap_q.size() == 2) chk("t6_cycles_delta", cap_q[1] - cap_q[0], 64'd10);

    rd(a8(11), LEN_8B, 9'h032, 64'h0, "t6_err");
    idle(1);
    drain();
    drive(1'b1, 1'b0, a8(0), LEN_8B, 9'h033, 64'h0);
    reset = 1'b1;
    drive(1'b1, 1'b0, a8(1), LEN_8B, 9'h034, 64'h0);
    chk("t6_rst_c2_valid", 64'(bus.af2cp_sTxC2.mmioRdValid), 64'h0);
    chk("t6_rst_c2_tid", 64'(bus.af2cp_sTxC2.hdr.tid), 64'h0);
    chk("t6_rst_c2_data", bus.af2cp_sTxC2.data, 64'h0);
    chk("t6_rst_rw0", csr_rw[0], 64'h0);
    chk("t6_rst_rw1", csr_rw[1], 64'h0);
    chk("t6_rst_pulse", 64'(csr_wr_pulse), 64'h0);
    idle(1);
    reset = 1'b0;
    idle(3);
    rd(a8(4), LEN_8B, 9'h035, 64'd0, "t6_errcnt_after_rst");
    rd(a8(6), LEN_8B, 9'h036, 64'd0, "t6_rw1_after_rst");
    idle(1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
